// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 2x2 stride-2 max-pool window sequencer.
package maxpool_pkg;

  localparam int LANES      = 4;
  localparam int WIN_CYCLES = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    RD3   = 3'd4,
    CAPT  = 3'd5,
    WRITE = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Bit offset of a lane inside the packed pool word.
  function automatic int lane_lsb(input int lane, input int shift);
    return lane << shift;
  endfunction

endpackage

// File: rtl/maxpool_window_ctrl_if.sv
// Bus between the window sequencer and its input SRAM, pool datapath and output SRAM.
interface maxpool_window_ctrl_if
  import maxpool_pkg::*;
#(
  parameter int bits       = 16,
  parameter int bits_shift = 4,
  parameter int addr_w     = 6,
  parameter int oaddr_w    = 4
);

  logic                             rd_en;
  logic [addr_w-1:0]                rd_addr;
  logic [bits-1:0]                  rd_data;
  logic [(LANES<<bits_shift)-1:0]   pool_data;
  logic                             pool_start;
  logic [bits-1:0]                  pool_result;
  logic                             wr_en;
  logic [oaddr_w-1:0]               wr_addr;
  logic [bits-1:0]                  wr_data;

  modport master (
    output rd_en, rd_addr, pool_data, pool_start, wr_en, wr_addr, wr_data,
    input  rd_data, pool_result
  );

  modport slave (
    input  rd_en, rd_addr, pool_data, pool_start, wr_en, wr_addr, wr_data,
    output rd_data, pool_result
  );

endinterface

// File: rtl/maxpool_addr_gen.sv
// Output-window row/column counters and the derived input/output SRAM addresses.
module maxpool_addr_gen #(
  parameter int img_w   = 8,
  parameter int img_h   = 8,
  parameter int addr_w  = 6,
  parameter int oaddr_w = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [1:0]         rd_idx,
  output logic [addr_w-1:0]  rd_addr,
  output logic [oaddr_w-1:0] wr_addr,
  output logic               last_win
);

  localparam int OW = img_w / 2;
  localparam int OH = img_h / 2;

  logic [oaddr_w-1:0] orow;
  logic [oaddr_w-1:0] ocol;
  logic               col_end;
  int                 row_i;
  int                 col_i;

  assign col_end  = (ocol == oaddr_w'(OW - 1));
  assign last_win = col_end && (orow == oaddr_w'(OH - 1));

  // Counters fold back to zero after the last window so they never overflow.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      orow <= '0;
      ocol <= '0;
    end else if (clear || (advance && last_win)) begin
      orow <= '0;
      ocol <= '0;
    end else if (advance) begin
      if (col_end) begin
        ocol <= '0;
        orow <= orow + oaddr_w'(1);
      end else begin
        ocol <= ocol + oaddr_w'(1);
      end
    end
  end

  // rd_idx bit 1 selects the lower row of the window, bit 0 the right column.
  always_comb begin
    row_i   = 2 * int'(orow) + int'(rd_idx[1]);
    col_i   = 2 * int'(ocol) + int'(rd_idx[0]);
    rd_addr = addr_w'(row_i * img_w + col_i);
    wr_addr = oaddr_w'(int'(orow) * OW + int'(ocol));
  end

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Sequencer walking a feature map with a 2x2 stride-2 window feeding a 4-lane max-pool datapath.
// Optional macro MAXPOOL_WINDOW_CTRL_PERF_EN adds a saturating busy-cycle counter output.
module maxpool_window_ctrl
  import maxpool_pkg::*;
#(
  parameter int bits       = 16,
  parameter int bits_shift = 4,
  parameter int img_w      = 8,
  parameter int img_h      = 8,
  parameter int addr_w     = 6,
  parameter int oaddr_w    = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef MAXPOOL_WINDOW_CTRL_PERF_EN
  output logic [31:0] perf_cycles,
`endif
  maxpool_window_ctrl_if.master bus
);

  state_t                         state;
  state_t                         state_nxt;
  logic                           rd_en;
  logic [1:0]                     rd_idx;
  logic                           pool_start;
  logic                           wr_en;
  logic                           cnt_clear;
  logic                           cnt_adv;
  logic                           cap_en;
  logic [1:0]                     cap_lane;
  logic                           last_win;
  logic [addr_w-1:0]              rd_addr_w;
  logic [oaddr_w-1:0]             wr_addr_w;
  logic [(LANES<<bits_shift)-1:0] pool_q;

  maxpool_addr_gen #(
    .img_w   (img_w),
    .img_h   (img_h),
    .addr_w  (addr_w),
    .oaddr_w (oaddr_w)
  ) u_addr_gen (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (cnt_adv),
    .rd_idx   (rd_idx),
    .rd_addr  (rd_addr_w),
    .wr_addr  (wr_addr_w),
    .last_win (last_win)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Each read's data lands one cycle later, so lane k is captured in the state after RDk.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = 2'd0;
    pool_start = 1'b0;
    wr_en      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_adv    = 1'b0;
    cap_en     = 1'b0;
    cap_lane   = 2'd0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RD0;
          cnt_clear = 1'b1;
        end
      end
      RD0: begin
        busy = 1'b1; rd_en = 1'b1; rd_idx = 2'd0;
        state_nxt = RD1;
      end
      RD1: begin
        busy = 1'b1; rd_en = 1'b1; rd_idx = 2'd1;
        cap_en = 1'b1; cap_lane = 2'd0;
        state_nxt = RD2;
      end
      RD2: begin
        busy = 1'b1; rd_en = 1'b1; rd_idx = 2'd2;
        cap_en = 1'b1; cap_lane = 2'd1;
        state_nxt = RD3;
      end
      RD3: begin
        busy = 1'b1; rd_en = 1'b1; rd_idx = 2'd3;
        cap_en = 1'b1; cap_lane = 2'd2;
        state_nxt = CAPT;
      end
      CAPT: begin
        busy = 1'b1;
        cap_en = 1'b1; cap_lane = 2'd3;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1; pool_start = 1'b1; wr_en = 1'b1; cnt_adv = 1'b1;
        state_nxt = last_win ? DONE : RD0;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pool_q <= '0;
    else if (cap_en) pool_q[lane_lsb(int'(cap_lane), bits_shift) +: bits] <= bus.rd_data;
  end

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_en ? rd_addr_w : '0;
  assign bus.pool_data  = pool_q;
  assign bus.pool_start = pool_start;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_en ? wr_addr_w : '0;
  assign bus.wr_data    = wr_en ? bus.pool_result : '0;

`ifdef MAXPOOL_WINDOW_CTRL_PERF_EN
  // Cleared on an accepted start, then counts busy cycles and sticks at all-ones.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                            perf_cycles <= '0;
    else if (state == IDLE && start)       perf_cycles <= '0;
    else if (busy && perf_cycles != '1)    perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/maxpool_window_ctrl.md
Name: maxpool_window_ctrl

Overview:
- Sequencer for the 4-lane 2x2 max-pool datapath.
- Walks a feature map held in an external synchronous-read SRAM with a 2x2 window, stride 2.
- For each window: gathers the four pixels, presents them packed on the pool datapath input, pulses the datapath start, and writes the pooled result to an output SRAM.
- Sits between the layer-level controller (start/done) and the pool datapath plus its input and output memories.

Parameters:
- bits, 16, pixel width.
- bits_shift, 4, log2 of lane pitch in packed pool word; lane i occupies bits [(i<<bits_shift)+bits-1 : i<<bits_shift].
- img_w, 8, input width in pixels; must be even, >=2.
- img_h, 8, input height in pixels; must be even, >=2.
- addr_w, 6, input address width; must satisfy 2^addr_w >= img_w*img_h.
- oaddr_w, 4, output address width; must satisfy 2^oaddr_w >= (img_w/2)*(img_h/2).

Ports:
- clk_in  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one full pooling pass; sampled only in IDLE
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  input SRAM read strobe
- rd_addr  out  addr_w  input address, row-major (row*img_w+col)
- rd_data  in  bits  input SRAM data, valid the cycle after rd_en
- pool_data  out  4<<bits_shift  packed window to pool datapath
- pool_start  out  1  one-cycle start pulse to pool datapath
- pool_result  in  bits  pool datapath max output (combinational from pool_data)
- wr_en  out  1  output SRAM write strobe
- wr_addr  out  oaddr_w  output address, (orow*(img_w/2)+ocol)
- wr_data  out  bits  pooled value

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk_in. All outputs, pool_data lanes, and counters are cleared to 0; FSM returns to IDLE. Reset mid-pass abandons the pass; no done is issued.
- States: IDLE, RD0, RD1, RD2, RD3, CAPT, WRITE, DONE.
- IDLE: busy=0. On start=1 go to RD0 and clear orow/ocol.
- RD0..RD3: rd_en=1, busy=1. Addresses are (2*orow,2*ocol), (2*orow,2*ocol+1), (2*orow+1,2*ocol), (2*orow+1,2*ocol+1).
- Lane capture: rd_data is captured into lane k of pool_data one cycle after RDk issues. Lanes 0..2 are captured in RD1..RD3; lane 3 is captured in CAPT.
- WRITE: pool_data is stable, pool_start=1, wr_en=1, wr_data=pool_result, wr_addr = output index.
- Advance: ocol increments. At ocol = img_w/2-1, ocol wraps to 0 and orow increments. After the last window (orow=img_h/2-1, ocol=img_w/2-1), go to DONE; otherwise go to RD0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Timing: each window takes exactly 6 cycles. Taking the cycle where start is sampled as cycle 0, the first wr_en is at cycle 6 and done is at cycle 6*N+1, where N=(img_w/2)*(img_h/2).
- start while busy or in DONE is ignored. start held high in IDLE after DONE begins a new pass.
- pool_data holds its last value between windows and after the pass.
- Comparison semantics are unsigned; this block is data-agnostic.

Optional Feature:
- Macro: MAXPOOL_WINDOW_CTRL_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It is cleared when start is accepted and increments on every cycle busy=1. It holds its value after DONE, so a full pass reads 6*N. It saturates at all-ones.
- Undefined: port and counter are absent; no other behaviour change.

Decomposition:
- Shared package maxpool_pkg: state encoding localparams, LANES=4, lane pitch helper constant, window cycle count WIN_CYCLES=6.
- Optional sub-module maxpool_addr_gen: holds the orow/ocol counters and produces rd_addr/wr_addr and a last-window flag. The FSM stays in the top.

Test Plan:
- 4x4 map, pixel = address (0..15), start pulse -> writes 5,7,13,15 to addresses 0..3 at cycles 6,12,18,24; done at cycle 25; busy high cycles 1..24.
- Window with max in each lane position in turn (e.g. 0x00FF placed in lane 0, then 1, 2, 3, others 0x0001) -> pool_data lane packing checked bit-exact; wr_data=0x00FF each time.
- start re-asserted during busy and during DONE -> ignored; exactly N writes, one done pulse.
- rst_n asserted low during RD2 of window 1 -> outputs 0 immediately (async); no done; the next start restarts from window 0 at address 0.
- 8x8 map with values 0xFFFF..0xFFC0 descending -> 16 writes, each equal to the window's top-left pixel; wr_addr wraps correctly at ocol=3.
- PERF_EN build, 4x4 pass -> perf_cycles=24 after done, cleared to 0 on the next accepted start.
